// File: rtl/logic_gate_unit_if.sv
// Handshake/operand bus for logic_gate_unit: upstream operand channel plus downstream result channel.
interface logic_gate_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_en;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid, op, acc_en, in0, in1, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op, acc_en, in0, in1, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic stage with accumulator and wrapping transaction counter.
// Optional result flags (out_zero, out_parity) enabled by defining LOGIC_GATE_UNIT_FLAGS_EN.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    logic_gate_unit_if.slave   bus,
    input  logic               acc_clr,
    output logic [WIDTH-1:0]   acc,
    output logic [CNT_W-1:0]   txn_cnt
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_parity
`endif
);

    typedef enum logic [2:0] {
        OP_NAND  = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result;

    assign bus.in_ready  = !out_valid_q | bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign acc           = acc_q;
    assign txn_cnt       = cnt_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = out_valid_q & bus.out_ready;

    // A same-cycle clear overrides the stored accumulator as operand A.
    always_comb begin
        opa = bus.in0;
        if (bus.acc_en) begin
            opa = acc_clr ? '0 : acc_q;
        end
        opb = bus.in1;
    end

    always_comb begin
        result = '0;
        case (op_e'(bus.op))
            OP_NAND:  result = ~(opa & opb);
            OP_AND:   result = opa & opb;
            OP_OR:    result = opa | opb;
            OP_NOR:   result = ~(opa | opb);
            OP_XOR:   result = opa ^ opb;
            OP_XNOR:  result = ~(opa ^ opb);
            OP_NOTA:  result = ~opa;
            default:  result = opb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= result;
            cnt_q       <= cnt_q + 1'b1;
        end else if (deliver) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && bus.acc_en) begin
            acc_q <= result;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic zero_q;
    logic parity_q;

    assign out_zero   = zero_q;
    assign out_parity = parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (accept) begin
            zero_q   <= (result == '0);
            parity_q <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit (WIDTH=8, WIDTH=1 and CNT_W=2 instances).
module tb_logic_gate_unit;

    logic clk = 1'b0;
    logic rst;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(8)) bus8 ();
    logic_gate_unit_if #(.WIDTH(1)) bus1 ();
    logic_gate_unit_if #(.WIDTH(8)) bus2 ();

    logic       clr8, clr1, clr2;
    logic [7:0] acc8, acc2;
    logic [0:0] acc1;
    logic [7:0] cnt8, cnt1;
    logic [1:0] cnt2;
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic z8, p8, z1, p1, z2, p2;
`endif

    logic_gate_unit #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .bus(bus8), .acc_clr(clr8), .acc(acc8), .txn_cnt(cnt8)
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        , .out_zero(z8), .out_parity(p8)
`endif
    );

    logic_gate_unit #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .acc_clr(clr1), .acc(acc1), .txn_cnt(cnt1)
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        , .out_zero(z1), .out_parity(p1)
`endif
    );

    logic_gate_unit #(.WIDTH(8), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2), .acc_clr(clr2), .acc(acc2), .txn_cnt(cnt2)
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        , .out_zero(z2), .out_parity(p2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    logic [7:0] sweep_exp [8];
    logic [0:0] nand_exp  [4];
    logic [1:0] cnt_exp   [5];

    initial begin
        sweep_exp = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hCC};
        nand_exp  = '{1'b1, 1'b1, 1'b1, 1'b0};
        cnt_exp   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1;
        clr8 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        bus8.in_valid = 1'b0; bus8.op = 3'd0; bus8.acc_en = 1'b0; bus8.in0 = '0; bus8.in1 = '0; bus8.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.op = 3'd0; bus1.acc_en = 1'b0; bus1.in0 = '0; bus1.in1 = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.op = 3'd0; bus2.acc_en = 1'b0; bus2.in0 = '0; bus2.in1 = '0; bus2.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 32'(bus8.out_valid), 32'h0);
        chk("rst_out",       32'(bus8.out),       32'h0);
        chk("rst_acc",       32'(acc8),           32'h0);
        chk("rst_txn_cnt",   32'(cnt8),           32'h0);
        chk("rst_in_ready",  32'(bus8.in_ready),  32'h1);

        // op sweep, one result per cycle
        bus8.in_valid = 1'b1;
        bus8.in0 = 8'hF0;
        bus8.in1 = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            bus8.op = 3'(i);
            tick();
            chk($sformatf("sweep_out_op%0d", i), 32'(bus8.out), 32'(sweep_exp[i]));
            chk($sformatf("sweep_valid_op%0d", i), 32'(bus8.out_valid), 32'h1);
        end
        chk("sweep_txn_cnt", 32'(cnt8), 32'h8);
        bus8.in_valid = 1'b0;
        tick();
        chk("idle_valid_drop", 32'(bus8.out_valid), 32'h0);
        chk("idle_out_hold",   32'(bus8.out),       32'hCC);
        chk("idle_acc_unchanged", 32'(acc8),        32'h0);

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        bus8.in_valid = 1'b1;
        bus8.op = 3'd4; bus8.in0 = 8'h5A; bus8.in1 = 8'h5A;
        tick();
        chk("flag_out_xor",  32'(bus8.out), 32'h00);
        chk("flag_zero_1",   32'(z8),       32'h1);
        chk("flag_parity_0", 32'(p8),       32'h0);
        bus8.op = 3'd7; bus8.in1 = 8'h07;
        tick();
        chk("flag_out_pass", 32'(bus8.out), 32'h07);
        chk("flag_zero_0",   32'(z8),       32'h0);
        chk("flag_parity_1", 32'(p8),       32'h1);
        bus8.in_valid = 1'b0;
        tick();
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // backpressure: result must hold while the next request waits
        bus8.in_valid = 1'b1; bus8.op = 3'd1; bus8.in0 = 8'hAA; bus8.in1 = 8'h0F;
        tick();
        chk("bp_first_out", 32'(bus8.out), 32'h0A);
        bus8.out_ready = 1'b0;
        bus8.op = 3'd2; bus8.in0 = 8'h55; bus8.in1 = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold_out_%0d", i),   32'(bus8.out),       32'h0A);
            chk($sformatf("bp_hold_valid_%0d", i), 32'(bus8.out_valid), 32'h1);
            chk($sformatf("bp_in_ready_%0d", i),   32'(bus8.in_ready),  32'h0);
            chk($sformatf("bp_txn_cnt_%0d", i),    32'(cnt8),           32'h1);
        end
        bus8.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus8.in_ready), 32'h1);
        tick();
        chk("bp_next_out",   32'(bus8.out),       32'hF5);
        chk("bp_next_valid", 32'(bus8.out_valid), 32'h1);
        chk("bp_next_cnt",   32'(cnt8),           32'h2);

        // accumulate chain
        bus8.acc_en = 1'b1; clr8 = 1'b1; bus8.op = 3'd2; bus8.in0 = 8'hFF; bus8.in1 = 8'h01;
        tick();
        chk("acc_step1", 32'(acc8), 32'h01);
        clr8 = 1'b0; bus8.in1 = 8'h80;
        tick();
        chk("acc_step2", 32'(acc8), 32'h81);
        bus8.op = 3'd4; bus8.in1 = 8'hFF;
        tick();
        chk("acc_step3",     32'(acc8),     32'h7E);
        chk("acc_step3_out", 32'(bus8.out), 32'h7E);
        clr8 = 1'b1; bus8.op = 3'd2; bus8.in1 = 8'h01;
        tick();
        chk("acc_clr_with_accept", 32'(acc8), 32'h01);
        bus8.in_valid = 1'b0; bus8.acc_en = 1'b0;
        tick();
        chk("acc_clr_idle",     32'(acc8),           32'h00);
        chk("acc_clr_idle_cnt", 32'(cnt8),           32'h6);
        chk("acc_clr_idle_out", 32'(bus8.out),       32'h01);
        chk("acc_clr_idle_vld", 32'(bus8.out_valid), 32'h0);
        clr8 = 1'b0;

        // WIDTH=1 NAND truth table
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.in0 = 1'(i);
            bus1.in1 = 1'(i >> 1);
            tick();
            chk($sformatf("nand1_%0d", i), 32'(bus1.out), 32'(nand_exp[i]));
        end
        bus1.in_valid = 1'b0;
        tick();

        // CNT_W=2 wrap, then reset while a result is held
        bus2.in_valid = 1'b1; bus2.op = 3'd7; bus2.acc_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.in1 = 8'(i + 1);
            tick();
            chk($sformatf("cnt2_%0d", i), 32'(cnt2), 32'(cnt_exp[i]));
        end
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(bus2.out_valid), 32'h1);
        chk("pre_rst_acc",   32'(acc2),           32'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus2.out_valid), 32'h0);
        chk("mid_rst_acc",   32'(acc2),           32'h0);
        chk("mid_rst_cnt",   32'(cnt2),           32'h0);
        chk("mid_rst_out",   32'(bus2.out),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
